pixel_data_parser: RTL and testbench

Receive-side counterpart of the MIPI pixel packetiser: consumes 48-bit pixel words from the CSI-2 RX pixel output and reassembles one fixed-length miner payload per frame. Detects the SOF word, checks the header, unpacks DLEN payload bytes, and verifies the EOF marker. Presents the payload as one flat bus with a one-cycle valid pulse to the miner core. Malformed frames raise an error pulse and are dropped.

---
 rtl/pixel_data_parser.sv | 140 ++++++++++++++
 tb/tb_pixel_data_parser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_data_parser.sv
// Receive-side frame parser: rebuilds one DLEN-byte miner payload per frame from 48-bit pixel words.
// Frames are SOF, header twice, payload words, then an EOF tail (plus a DD word when DLEN%6 == 5).
module pixel_data_parser #(
    parameter int unsigned DLEN   = 32'h002b,
    parameter logic [7:0]  PHL_ID = 8'h00,
    parameter logic [7:0]  DTYPE  = 8'h01
) (
    input  logic                rx_pixel_clk,
    input  logic                rst,
    input  logic [47:0]         pixel_value,
    input  logic                pixel_valid,
    output logic [DLEN*8-1:0]   data,
    output logic                data_valid,
    output logic                frame_error,
    output logic                busy
);

    localparam int unsigned REM  = DLEN % 6;
    localparam int unsigned BODY = DLEN - REM;
    localparam int          KW   = $clog2(DLEN + 7);
    localparam logic [31:0] DLEN_W = 32'(DLEN);

    localparam logic [47:0] SOF_WORD = 48'h01000000FFEA;
    localparam logic [47:0] HDR_WORD = {PHL_ID, DLEN_W[7:0], DLEN_W[15:8],
                                        DLEN_W[23:16], DLEN_W[31:24], DTYPE};
    localparam logic [47:0] EXT_WORD = 48'h0000000000DD;
    localparam logic [47:0] DATA_LANES = (48'h1 << (8 * REM)) - 48'h1;
    localparam logic [47:0] TAIL_MASK  = ~DATA_LANES;
    // For REM == 5 the DD byte shifts out of the word, leaving only AA in lane 5.
    localparam logic [47:0] TAIL_EXP   = 48'h00000000DDAA << (8 * REM);

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        HDR2,
        PAYLOAD,
        TAIL,
        EXT
    } state_t;

    state_t               state;
    logic [KW-1:0]        k;
    logic [KW+2:0]        off;
    // 48 spare bits let every store be a full word at byte k without range checks.
    logic [DLEN*8+47:0]   shadow;
    logic [DLEN*8+47:0]   shadow_wr;

    assign off = {k, 3'b000};

    always_comb begin
        shadow_wr = shadow;
        shadow_wr[off +: 48] = pixel_value;
    end

    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            shadow      <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (pixel_valid) begin
                if (pixel_value == SOF_WORD) begin
                    if (state != IDLE) begin
                        frame_error <= 1'b1;
                    end
                    state <= HDR1;
                    busy  <= 1'b1;
                    k     <= '0;
                end else begin
                    case (state)
                        IDLE: ;
                        HDR1: begin
                            if (pixel_value == HDR_WORD) begin
                                state <= HDR2;
                            end else begin
                                frame_error <= 1'b1;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                        HDR2: begin
                            if (pixel_value == HDR_WORD) begin
                                state <= (BODY == 0) ? TAIL : PAYLOAD;
                            end else begin
                                frame_error <= 1'b1;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                        PAYLOAD: begin
                            shadow <= shadow_wr;
                            k      <= k + KW'(6);
                            if (({1'b0, k} + (KW+1)'(12)) > (KW+1)'(BODY)) begin
                                state <= TAIL;
                            end
                        end
                        TAIL: begin
                            if ((pixel_value & TAIL_MASK) == TAIL_EXP) begin
                                shadow <= shadow_wr;
                                if (REM == 5) begin
                                    state <= EXT;
                                end else begin
                                    data       <= shadow_wr[DLEN*8-1:0];
                                    data_valid <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= IDLE;
                                end
                            end else begin
                                frame_error <= 1'b1;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                        EXT: begin
                            if (pixel_value == EXT_WORD) begin
                                data       <= shadow[DLEN*8-1:0];
                                data_valid <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                        default: begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_data_parser.sv
// Directed bench for pixel_data_parser: DLEN=43, DLEN=5 and DLEN=12 builds driven from vector tables.
module tb_pixel_data_parser;

    localparam logic [47:0] SOF = 48'h01000000FFEA;
    localparam logic [47:0] H43 = 48'h002B00000001;
    localparam logic [47:0] H5  = 48'h000500000001;
    localparam logic [47:0] H12 = 48'h000C00000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] pix;
    logic        pval;
    logic [1:0]  sel;
    logic        v43, v5, v12;

    logic [343:0] d43;
    logic [39:0]  d5;
    logic [95:0]  d12;
    logic dv43, fe43, bz43, dv5, fe5, bz5, dv12, fe12, bz12;

    always #5 clk = ~clk;

    assign v43 = pval && (sel == 2'd0);
    assign v5  = pval && (sel == 2'd1);
    assign v12 = pval && (sel == 2'd2);

    pixel_data_parser #(.DLEN(43)) u43 (
        .rx_pixel_clk(clk), .rst(rst), .pixel_value(pix), .pixel_valid(v43),
        .data(d43), .data_valid(dv43), .frame_error(fe43), .busy(bz43));
    pixel_data_parser #(.DLEN(5)) u5 (
        .rx_pixel_clk(clk), .rst(rst), .pixel_value(pix), .pixel_valid(v5),
        .data(d5), .data_valid(dv5), .frame_error(fe5), .busy(bz5));
    pixel_data_parser #(.DLEN(12)) u12 (
        .rx_pixel_clk(clk), .rst(rst), .pixel_value(pix), .pixel_valid(v12),
        .data(d12), .data_valid(dv12), .frame_error(fe12), .busy(bz12));

    // exp is {data_valid, frame_error, busy} after the beat's clock edge
    typedef struct {
        logic [47:0] pix;
        logic        val;
        logic [1:0]  sel;
        logic [2:0]  exp;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [343:0] got, input logic [343:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [47:0] p, input logic v, input logic [1:0] s, input logic [2:0] e);
        vec_t r;
        r.pix = p; r.val = v; r.sel = s; r.exp = e;
        tbl.push_back(r);
    endtask

    // A stall beat carries the SOF pattern to prove invalid cycles are ignored.
    task automatic beat(input logic [47:0] p, input logic [1:0] s, input logic [2:0] e, input bit toggle);
        add(p, 1'b1, s, e);
        if (toggle) add(SOF, 1'b0, s, {2'b00, e[0]});
    endtask

    function automatic logic [47:0] pw(input int n, input logic [7:0] x);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[i*8 +: 8] = 8'(6*n + i) ^ x;
        return r;
    endfunction

    function automatic logic [343:0] exp43(input logic [7:0] x);
        logic [343:0] r;
        for (int i = 0; i < 43; i++) r[i*8 +: 8] = 8'(i) ^ x;
        return r;
    endfunction

    task automatic frame43(input logic [7:0] x, input bit toggle, input bit bad_tail, input logic [2:0] sof_e);
        logic [7:0] eof;
        eof = bad_tail ? 8'hAB : 8'hAA;
        beat(SOF, 2'd0, sof_e, toggle);
        beat(H43, 2'd0, 3'b001, toggle);
        beat(H43, 2'd0, 3'b001, toggle);
        for (int n = 0; n < 7; n++) beat(pw(n, x), 2'd0, 3'b001, toggle);
        beat({24'h0, 8'hDD, eof, 8'h2A ^ x}, 2'd0, bad_tail ? 3'b010 : 3'b100, toggle);
    endtask

    task automatic run_table(input string name);
        logic [2:0] got;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            pix  = tbl[i].pix;
            pval = tbl[i].val;
            sel  = tbl[i].sel;
            @(posedge clk);
            #1;
            case (tbl[i].sel)
                2'd0:    got = {dv43, fe43, bz43};
                2'd1:    got = {dv5, fe5, bz5};
                default: got = {dv12, fe12, bz12};
            endcase
            check($sformatf("%s[%0d] dv/fe/busy", name, i), {341'b0, got}, {341'b0, tbl[i].exp});
        end
        @(negedge clk);
        pval = 1'b0;
        tbl.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_d43"}, d43, '0);
        check({name, "_d5"}, {304'b0, d5}, '0);
        check({name, "_d12"}, {248'b0, d12}, '0);
        check({name, "_flags"}, {335'b0, dv43, fe43, bz43, dv5, fe5, bz5, dv12, fe12, bz12}, '0);
    endtask

    initial begin
        rst = 1'b1; pix = '0; pval = 1'b0; sel = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // good frame, then a back-to-back frame whose SOF follows the EOF beat directly
        frame43(8'h55, 1'b0, 1'b0, 3'b001);
        frame43(8'h00, 1'b0, 1'b0, 3'b001);
        run_table("good_b2b");
        check("good_data", d43, exp43(8'h00));
        check("good_byte0", {336'b0, d43[7:0]}, {336'b0, 8'h00});
        check("good_byte42", {336'b0, d43[343:336]}, {336'b0, 8'h2A});

        frame43(8'h00, 1'b1, 1'b0, 3'b001);
        run_table("stall");
        check("stall_data", d43, exp43(8'h00));

        beat(SOF, 2'd0, 3'b001, 1'b0);
        beat(H43, 2'd0, 3'b001, 1'b0);
        beat({H43[47:8], 8'h02}, 2'd0, 3'b010, 1'b0);
        add(48'h0, 1'b0, 2'd0, 3'b000);
        run_table("bad_hdr");
        check("bad_hdr_data", d43, exp43(8'h00));

        frame43(8'h80, 1'b0, 1'b1, 3'b001);
        run_table("bad_eof");
        check("bad_eof_data", d43, exp43(8'h00));

        beat(SOF, 2'd0, 3'b001, 1'b0);
        beat(H43, 2'd0, 3'b001, 1'b0);
        beat(H43, 2'd0, 3'b001, 1'b0);
        beat(pw(0, 8'h33), 2'd0, 3'b001, 1'b0);
        beat(pw(1, 8'h33), 2'd0, 3'b001, 1'b0);
        frame43(8'h33, 1'b0, 1'b0, 3'b011);
        run_table("abort");
        check("abort_data", d43, exp43(8'h33));

        beat(SOF, 2'd1, 3'b001, 1'b0);
        beat(H5, 2'd1, 3'b001, 1'b0);
        beat(H5, 2'd1, 3'b001, 1'b0);
        beat(48'hAA5544332211, 2'd1, 3'b001, 1'b0);
        beat(48'h0000000000DD, 2'd1, 3'b100, 1'b0);
        run_table("dlen5");
        check("dlen5_data", {304'b0, d5}, {304'b0, 40'h5544332211});

        beat(SOF, 2'd2, 3'b001, 1'b0);
        beat(H12, 2'd2, 3'b001, 1'b0);
        beat(H12, 2'd2, 3'b001, 1'b0);
        beat(pw(0, 8'h00), 2'd2, 3'b001, 1'b0);
        beat(pw(1, 8'h00), 2'd2, 3'b001, 1'b0);
        beat(48'h00000000DDAA, 2'd2, 3'b100, 1'b0);
        run_table("dlen12");
        check("dlen12_data", {248'b0, d12}, {248'b0, 96'h0B0A09080706050403020100});

        // reset in the middle of the payload
        beat(SOF, 2'd0, 3'b001, 1'b0);
        beat(H43, 2'd0, 3'b001, 1'b0);
        beat(H43, 2'd0, 3'b001, 1'b0);
        for (int n = 0; n < 5; n++) beat(pw(n, 8'h11), 2'd0, 3'b001, 1'b0);
        run_table("pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        #1;
        check_all_zero("mid_rst_hold");
        rst = 1'b0;
        frame43(8'h22, 1'b0, 1'b0, 3'b001);
        add(48'h0, 1'b0, 2'd0, 3'b000);
        run_table("post_rst");
        check("post_rst_data", d43, exp43(8'h22));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
